// File: rtl/punc_pkg.sv
// Shared PUnC fetch definitions: default widths, reset PC and the queue entry layout.
package punc_pkg;

    localparam int          PUNC_DATA_W   = 16;
    localparam int          PUNC_ADDR_W   = 16;
    localparam int unsigned PUNC_RESET_PC = 0;

    typedef struct packed {
        logic [PUNC_DATA_W-1:0] data;
        logic [PUNC_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/punc_sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from storage.
module punc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Flush wins over any push/pop presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/punc_fetch_queue.sv
// Decoupled fetch front end: issues in-order memory reads against reserved queue
// slots, drops responses belonging to a pre-redirect stream, and buffers PC-tagged words.
module punc_fetch_queue
    import punc_pkg::*;
#(
    parameter int                DATA_W   = PUNC_DATA_W,
    parameter int                ADDR_W   = PUNC_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PUNC_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] fetch_pc_debug,
    output logic              proto_err
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]     count, outstanding, discard_cnt;
    logic [CW:0]       reserved;
    logic              req_fire, resp_ok, spurious, push, pop;
    logic [DATA_W+ADDR_W-1:0] head;

    // Every in-flight request owns a queue slot, so a push can never overflow.
    assign reserved      = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = !rst && !halt && !redirect_valid && (reserved < DEPTH_L);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign resp_ok  = mem_resp_valid && (outstanding != '0);
    assign spurious = mem_resp_valid && (outstanding == '0);
    assign push     = resp_ok && !redirect_valid && (discard_cnt == '0);

    assign inst_valid = (count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    assign inst_data      = head[ADDR_W +: DATA_W];
    assign inst_pc        = head[ADDR_W-1:0];
    assign fetch_pc_debug = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            proto_err   <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc    <= redirect_pc;
                resp_pc     <= redirect_pc;
                discard_cnt <= outstanding - CW'(resp_ok);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 1'b1;
                if (push)     resp_pc  <= resp_pc + 1'b1;
                if (resp_ok && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
            end
            if (spurious) proto_err <= 1'b1;
        end
    end

    punc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({mem_resp_data, resp_pc}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_punc_fetch_queue.sv
// Bench for punc_fetch_queue: fixed-latency memory model with epoch tags and an
// instruction scoreboard, a per-cycle vector table and hand sequences for corner cases.
module tb_punc_fetch_queue;
    import punc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, halt, redirect_valid, mem_req_valid, mem_req_ready;
    logic [15:0] redirect_pc, mem_req_addr, mem_resp_data, inst_data, inst_pc, fetch_pc_debug;
    logic        mem_resp_valid, inst_valid, inst_ready, proto_err;

    always #5 clk = ~clk;

    punc_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_pc_debug (fetch_pc_debug),
        .proto_err      (proto_err)
    );

    typedef struct {
        logic [15:0] addr;
        int          ep;
        int          due;
    } mreq_t;

    typedef struct {
        logic        ir;
        logic        redir;
        logic [15:0] rpc;
        logic        erv;
        logic [15:0] eaddr;
        logic        eiv;
        logic [15:0] epc;
    } vec_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];
    logic [15:0]  pop_log[$];
    vec_t         vec[20];
    int           cyc, epoch, lat, checks, errors;
    logic         spur;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive the memory response for this cycle, then move to the sampling edge.
    task automatic half_a();
        mreq_t m;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (spur) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 16'hDEAD;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(m.addr);
            if (m.ep == epoch && !redirect_valid)
                exp_q.push_back('{data: mem_word(m.addr), pc: m.addr});
        end
        if (redirect_valid && !rst) begin
            epoch++;
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Record request fires and check pops, then advance past the next active edge.
    task automatic half_b();
        fetch_entry_t e;
        if (mem_req_valid && mem_req_ready)
            mq.push_back('{addr: mem_req_addr, ep: epoch, due: cyc + lat});
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected no instruction (cycle %0d)", inst_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_data", inst_data, e.data);
            end
            pop_log.push_back(inst_pc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        mq.delete();
        exp_q.delete();
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; spur = 1'b0;
        repeat (2) begin
            half_a();
            chk("rst_req_valid", mem_req_valid, 0);
            chk("rst_inst_valid", inst_valid, 0);
            half_b();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        inst_ready = 1'b0; spur = 1'b0;
        cyc = 0; epoch = 0; lat = 2; checks = 0; errors = 0;

        // ir, redir, rpc, req_valid, req_addr, inst_valid, inst_pc
        vec = '{
            '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000},
            '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0001},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001},
            '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0002},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0003},
            '{1'b1, 1'b1, 16'h3000, 1'b0, 16'h0000, 1'b0, 16'h0000},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h3000, 1'b0, 16'h0000},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h3001, 1'b0, 16'h0000},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h3002, 1'b0, 16'h0000},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h3003, 1'b1, 16'h3000}
        };

        @(posedge clk);
        #1;
        do_reset();

        // Fill to DEPTH with no consumer, single pop, then redirect with a response in that cycle.
        for (int i = 0; i < 20; i++) begin
            inst_ready     = vec[i].ir;
            redirect_valid = vec[i].redir;
            redirect_pc    = vec[i].rpc;
            half_a();
            if (i == 0) begin
                chk("reset_proto_err", proto_err, 0);
                chk("reset_fetch_pc", fetch_pc_debug, 16'h0000);
            end
            chk("tbl_req_valid", mem_req_valid, vec[i].erv);
            if (vec[i].erv) chk("tbl_req_addr", mem_req_addr, vec[i].eaddr);
            chk("tbl_inst_valid", inst_valid, vec[i].eiv);
            if (vec[i].eiv) chk("tbl_inst_pc", inst_pc, vec[i].epc);
            half_b();
        end
        redirect_valid = 1'b0;

        // Halt: no requests, in-flight words still delivered.
        halt = 1'b1; inst_ready = 1'b1;
        repeat (8) begin
            half_a();
            chk("halt_req_valid", mem_req_valid, 0);
            half_b();
        end
        chk("halt_drain_left", exp_q.size(), 0);
        chk("halt_drain_inst_valid", inst_valid, 0);

        // Memory not ready: address holds.
        halt = 1'b0; mem_req_ready = 1'b0;
        half_a();
        chk("stall_req_valid", mem_req_valid, 1);
        chk("stall_req_addr", mem_req_addr, 16'h3004);
        half_b();
        chk("stall_fetch_pc", fetch_pc_debug, 16'h3004);
        mem_req_ready = 1'b1;

        // Two requests in flight with no response in the redirect cycle; redirect to the top of memory.
        lat = 4;
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        half_a();
        chk("redir_no_req", mem_req_valid, 0);
        half_b();
        redirect_valid = 1'b0;
        half_a();
        chk("redir1_req_valid", mem_req_valid, 1);
        chk("redir1_req_addr", mem_req_addr, 16'h0100);
        half_b();
        half_a();
        chk("redir1_req_addr2", mem_req_addr, 16'h0101);
        half_b();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        half_a();
        chk("redir2_no_req", mem_req_valid, 0);
        chk("redir2_inst_valid", inst_valid, 0);
        half_b();
        redirect_valid = 1'b0;
        pop_log.delete();
        half_a();
        chk("wrap_req_valid", mem_req_valid, 1);
        chk("wrap_req_addr0", mem_req_addr, 16'hFFFF);
        half_b();
        half_a();
        chk("wrap_req_addr1", mem_req_addr, 16'h0000);
        half_b();
        repeat (12) begin half_a(); half_b(); end
        if (pop_log.size() >= 2) begin
            chk("wrap_first_pc", pop_log[0], 16'hFFFF);
            chk("wrap_second_pc", pop_log[1], 16'h0000);
        end else begin
            checks++;
            errors++;
            $display("FAIL wrap_pops: got %0d pops expected at least 2", pop_log.size());
        end

        // Spurious response with nothing outstanding.
        halt = 1'b1; inst_ready = 1'b0;
        repeat (8) begin half_a(); half_b(); end
        chk("pre_spur_proto_err", proto_err, 0);
        chk("pre_spur_mq_empty", mq.size(), 0);
        spur = 1'b1;
        half_a();
        half_b();
        spur = 1'b0;
        chk("spur_proto_err", proto_err, 1);
        inst_ready = 1'b1;
        repeat (6) begin half_a(); half_b(); end
        chk("spur_no_push", exp_q.size(), 0);
        chk("spur_queue_empty", inst_valid, 0);
        chk("spur_sticky", proto_err, 1);
        do_reset();
        chk("spur_cleared_by_rst", proto_err, 0);

        // Streaming from reset with 2-cycle memory: one request and one instruction per cycle.
        lat = 2; inst_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            half_a();
            chk("stream_req_valid", mem_req_valid, 1);
            chk("stream_req_addr", mem_req_addr, 16'(c));
            if (c >= 3) begin
                chk("stream_inst_valid", inst_valid, 1);
                chk("stream_inst_pc", inst_pc, 16'(c - 3));
            end
            half_b();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
